hard_drop_ctrl: RTL

Initiator side of the landing-row calculation handshake. It issues `cal_bottom_en` requests to the landing-row calculator and consumes `finish_cal_bottom`/`bottom_y`. It serves two clients: a ghost-piece refresher, re-run whenever the falling piece or the board changes, and the space-key hard drop, which yields the row the piece is placed at. It sits between the key decoder/game FSM and the calculator.

---
 rtl/hard_drop_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hard_drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hard_drop_ctrl
// Brief   : Landing-row request arbiter serving the ghost refresher and the
//           hard drop over a single calculator handshake.
// Revision: 1.0 - initial release
// ============================================================================
module hard_drop_ctrl #(
   parameter int unsigned TIMEOUT = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       space_pulse,
   input  logic       board_change,
   input  logic [2:0] block,
   input  logic [1:0] status,
   input  logic [4:0] pos_x,
   output logic       cal_bottom_en,
   input  logic       finish_cal_bottom,
   input  logic [4:0] bottom_y,
   output logic [4:0] ghost_y,
   output logic       ghost_valid,
   output logic [4:0] drop_y,
   output logic       drop_valid,
   output logic       hold,
   output logic       busy,
   output logic       timeout_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT     = 2'd2,
      DROP_OUT = 2'd3
   } state_t;

   localparam logic [4:0] C_TO_LAST = 5'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [9:0]  key_q, req_key_q, req_key_d;
   logic        dirty_q, dirty_d;
   logic        drop_pend_q, drop_pend_d;
   logic        is_drop_q, is_drop_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        cal_en_q, cal_en_d;
   logic [4:0]  ghost_y_q, ghost_y_d;
   logic        ghost_valid_q, ghost_valid_d;
   logic [4:0]  drop_y_q, drop_y_d;
   logic        drop_valid_q, drop_valid_d;
   logic        hold_q, hold_d;
   logic        busy_q;
   logic        terr_q, terr_d;

   logic [9:0]  w_key;
   logic        w_change;

   assign w_key    = {block, status, pos_x};
   assign w_change = (w_key != key_q) || board_change;

   always_comb begin
      state_d       = state_q;
      req_key_d     = req_key_q;
      dirty_d       = dirty_q || w_change;
      drop_pend_d   = drop_pend_q || space_pulse;
      is_drop_d     = is_drop_q;
      cnt_d         = cnt_q;
      cal_en_d      = 1'b0;
      ghost_y_d     = ghost_y_q;
      ghost_valid_d = ghost_valid_q && !w_change;
      drop_y_d      = drop_y_q;
      drop_valid_d  = 1'b0;
      hold_d        = hold_q;
      terr_d        = terr_q;

      unique case (state_q)
         IDLE: begin
            if (drop_pend_d) begin
               state_d   = REQ;
               is_drop_d = 1'b1;
               hold_d    = 1'b1;
               cal_en_d  = 1'b1;
            end else if (dirty_d) begin
               state_d   = REQ;
               is_drop_d = 1'b0;
               cal_en_d  = 1'b1;
            end
         end
         REQ: begin
            // The calculator samples the key this cycle, so only a board
            // rewrite landing now can still make the answer stale.
            req_key_d = w_key;
            dirty_d   = board_change;
            cnt_d     = 5'd0;
            state_d   = WAIT;
         end
         WAIT: begin
            cnt_d = 5'(cnt_q + 5'd1);
            if (finish_cal_bottom) begin
               if (dirty_d || (w_key != req_key_q)) begin
                  dirty_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ghost_y_d     = bottom_y;
                  ghost_valid_d = 1'b1;
                  if (is_drop_q) begin
                     drop_y_d     = bottom_y;
                     drop_valid_d = 1'b1;
                     state_d      = DROP_OUT;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end else if (cnt_q == C_TO_LAST) begin
               terr_d      = 1'b1;
               dirty_d     = 1'b1;
               drop_pend_d = 1'b0;
               is_drop_d   = 1'b0;
               hold_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         DROP_OUT: begin
            drop_pend_d = 1'b0;
            is_drop_d   = 1'b0;
            hold_d      = 1'b0;
            dirty_d     = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         key_q         <= '0;
         req_key_q     <= '0;
         dirty_q       <= 1'b1;
         drop_pend_q   <= 1'b0;
         is_drop_q     <= 1'b0;
         cnt_q         <= '0;
         cal_en_q      <= 1'b0;
         ghost_y_q     <= '0;
         ghost_valid_q <= 1'b0;
         drop_y_q      <= '0;
         drop_valid_q  <= 1'b0;
         hold_q        <= 1'b0;
         busy_q        <= 1'b0;
         terr_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         key_q         <= w_key;
         req_key_q     <= req_key_d;
         dirty_q       <= dirty_d;
         drop_pend_q   <= drop_pend_d;
         is_drop_q     <= is_drop_d;
         cnt_q         <= cnt_d;
         cal_en_q      <= cal_en_d;
         ghost_y_q     <= ghost_y_d;
         ghost_valid_q <= ghost_valid_d;
         drop_y_q      <= drop_y_d;
         drop_valid_q  <= drop_valid_d;
         hold_q        <= hold_d;
         busy_q        <= (state_d != IDLE);
         terr_q        <= terr_d;
      end
   end

   assign cal_bottom_en = cal_en_q;
   assign ghost_y       = ghost_y_q;
   assign ghost_valid   = ghost_valid_q;
   assign drop_y        = drop_y_q;
   assign drop_valid    = drop_valid_q;
   assign hold          = hold_q;
   assign busy          = busy_q;
   assign timeout_err   = terr_q;

endmodule
`default_nettype wire
